scoreboard_mc: RTL and testbench
================================

// Module: scoreboard_mc
// PURPOSE
//  Multi-outstanding register scoreboard for the CGRA dispatcher: a per-TID, per-register pending-write counter (not a single bit).
//  Dispatch checks a block's input-register map for RAW hazards against the read TID, then reserves destination registers for the issuing TID.
//  NUM_WB independent write-back ports each release one register across a bitmap of TIDs.
//  Adds per-TID flush (thread kill), underflow error and global idle reporting.
// PARAMETERS
//  NUM_TID   256  thread IDs tracked
//  NUM_REGS  34   registers per TID (0..31 GPR, 32 CR, 33 PR)
//  NUM_WB    2    write-back ports
//  CNT_W     2    pending-write counter width; CNT_MAX = 2**CNT_W-1
//  TID_W     $clog2(NUM_TID);  REG_W  7
// PORTS
//  clk             in   1                 clock
//  rst             in   1                 synchronous reset, active-high
//  input_regs_map  in   NUM_REGS          registers read by candidate block
//  rd_tid          in   TID_W             TID checked for collision
//  rd_valid        in   1                 check request
//  rsv_regs_map    in   NUM_REGS          registers to reserve
//  rsv_tid         in   TID_W             TID reserving
//  rsv_valid       in   1                 reserve request
//  rsv_ready       out  1                 reservation accepted this cycle
//  wb_tid_bitmap   in   NUM_WB*NUM_TID    per-port TIDs released
//  wb_dest_reg     in   NUM_WB*REG_W      per-port released register
//  wb_valid        in   NUM_WB            per-port release valid
//  flush_tid       in   TID_W             TID whose row is cleared
//  flush_valid     in   1                 flush request
//  collision       out  1                 RAW hazard on rd_tid (combinational)
//  idle            out  1                 registered: every counter zero
//  err_underflow   out  1                 sticky: release of zero counter seen
// BEHAVIOUR
//  - Reset: all counters 0; idle=1; err_underflow=0. rsv_ready and collision follow the reset state combinationally.
//  - busy[t][r] = (cnt[t][r] != 0).
//  - collision = rd_valid & |(input_regs_map & busy[rd_tid]).
//    Same-cycle reservations never affect it; they become visible one cycle later.
//  - Same-cycle release of (rd_tid, r) still counts as busy; see WB bypass under CONFIGURATION.
//  - rsv_ready = !(rsv_valid & any r in rsv_regs_map with cnt[rsv_tid][r]==CNT_MAX).
//  - Accepted reservation: each mapped counter +1 at the next edge. A rejected reservation changes nothing; the dispatcher retries.
//  - Release per port p: for every TID set in wb_tid_bitmap[p], cnt[t][wb_dest_reg[p]] -1.
//    Ports hitting the same counter sum their decrements.
//    wb_dest_reg >= NUM_REGS is ignored.
//  - Update rule: cnt_next = cnt + inc - dec, all events in one cycle (fusion of reserve and release on the same TID is legal).
//  - Underflow: if dec > cnt + inc, result clamps to 0 and err_underflow sets (cleared only by rst).
//  - Flush: row flush_tid becomes all-zero at the next edge. It overrides reserve and release to that TID in the same cycle, with no underflow flagged.
//  - idle: registered; equals "all cnt_next == 0".
//  - rst asserted mid-operation: all state cleared at that edge; inputs ignored that cycle.
// CONFIGURATION
//  SCOREBOARD_WB_BYPASS_EN defined:
//   collision uses (cnt - dec_this_cycle) != 0 for rd_tid.
//   A register whose last pending write retires this cycle does not collide.
//  Undefined: the raw busy[] is used (conservative; adds one cycle of hazard).
// STRUCTURE
//  Package scoreboard_pkg:
//   REG_CR=32, REG_PR=33, NUM_REGS default.
//   typedef reg_map_t (logic [NUM_REGS-1:0]).
//   Function clamp_sub.
//  Sub-module scoreboard_row: one TID's NUM_REGS counters.
//   Inputs: inc map, per-register dec count, flush.
//   Outputs: busy map, zero flag, underflow.
//   Generated NUM_TID times. Top level holds read/reserve muxes and the OR-reductions.
// TESTING
//  1 Reset, then rd_tid=100, map=34'h3_FFFF_FFFF -> collision=0, idle=1, rsv_ready=1.
//  2 Reserve TID5 regs 0-3, next cycle read TID5 map=0x6 -> collision=1; map=0xF0 -> 0; idle=0.
//  3 Reserve TID7 reg0 three times (CNT_W=2), fourth rsv -> rsv_ready=0, cnt stays 3.
//    Then 3 releases (2 ports in 1 cycle + 1) -> reg0 free, idle=1.
//  4 Fusion, same cycle: rsv TID7 regs 0-3 and wb port0 TID7 reg5 (reg5 held) -> reg5 free, reg0 busy next cycle.
//    Release of idle reg -> err_underflow=1, sticky.
//  5 Ports 0/1 bitmaps {10,11} reg2, TID10 holding reg2 once, rd_tid=10 map=0x4:
//    bypass off -> collision=1; bypass on -> 0. Next cycle -> 0.
//  6 TID22 holds PR (bit33); flush_valid tid22 with concurrent rsv TID22 CR -> both clear next cycle, no err.
//    rst mid-burst -> all zero.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared register-map types and helpers for the multi-outstanding scoreboard
package scoreboard_pkg;
  localparam int NUM_REGS = 34;
  localparam int REG_CR = 32;
  localparam int REG_PR = 33;
  typedef logic [NUM_REGS-1:0] reg_map_t;
  function automatic logic [7:0] clamp_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a - b : 8'd0;
  endfunction
endpackage

// File: rtl/scoreboard_row.sv
// scoreboard_row: one TID's pending-write counters (SCOREBOARD_WB_BYPASS_EN selects the hazard view)
module scoreboard_row
  import scoreboard_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  reg_map_t                         inc,
  input  logic [NUM_REGS-1:0][DEC_W-1:0]   dec,
  input  logic                             flush,
  output reg_map_t                         busy,
  output reg_map_t                         full,
  output logic                             zero,
  output logic                             underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] nxt [NUM_REGS];
  reg_map_t uf;
  logic [7:0] s, d, diff;
  logic nz;
  always_comb begin
    s = '0;
    d = '0;
    diff = '0;
    nz = 1'b0;
    uf = '0;
    busy = '0;
    full = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      s = 8'(cnt[r]) + 8'(inc[r]);
      d = 8'(dec[r]);
      diff = clamp_sub(s, d);
      nxt[r] = flush ? '0 : diff[CNT_W-1:0];
      uf[r] = !flush && (d > s);
`ifdef SCOREBOARD_WB_BYPASS_EN
      busy[r] = 8'(cnt[r]) > d;
`else
      busy[r] = cnt[r] != '0;
`endif
      full[r] = cnt[r] == CNT_MAX;
      nz = nz | (nxt[r] != '0);
    end
  end
  assign zero = !nz;
  assign underflow = |uf;
  always_ff @(posedge clk)
    for (int r = 0; r < NUM_REGS; r++) cnt[r] <= rst ? '0 : nxt[r];
endmodule

// File: rtl/scoreboard_mc.sv
// scoreboard_mc: per-TID multi-outstanding register scoreboard (optional SCOREBOARD_WB_BYPASS_EN)
module scoreboard_mc
  import scoreboard_pkg::*;
#(
  parameter int NUM_TID = 256,
  parameter int NUM_WB  = 2,
  parameter int CNT_W   = 2,
  parameter int REG_W   = 7,
  localparam int TID_W  = $clog2(NUM_TID)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  reg_map_t                   input_regs_map,
  input  logic [TID_W-1:0]           rd_tid,
  input  logic                       rd_valid,
  input  reg_map_t                   rsv_regs_map,
  input  logic [TID_W-1:0]           rsv_tid,
  input  logic                       rsv_valid,
  output logic                       rsv_ready,
  input  logic [NUM_WB*NUM_TID-1:0]  wb_tid_bitmap,
  input  logic [NUM_WB*REG_W-1:0]    wb_dest_reg,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [TID_W-1:0]           flush_tid,
  input  logic                       flush_valid,
  output logic                       collision,
  output logic                       idle,
  output logic                       err_underflow
);
  localparam int DEC_W = $clog2(NUM_WB + 1);
  reg_map_t busy [NUM_TID];
  reg_map_t full [NUM_TID];
  logic [NUM_TID-1:0] zero, uf;
  logic accept;
  assign rsv_ready = !(rsv_valid && |(rsv_regs_map & full[rsv_tid]));
  assign accept = rsv_valid && rsv_ready;
  assign collision = rd_valid && |(input_regs_map & busy[rd_tid]);
  for (genvar t = 0; t < NUM_TID; t++) begin : g_row
    logic [NUM_REGS-1:0][DEC_W-1:0] dec;
    // out-of-range destinations never match any r, so they release nothing
    always_comb begin
      dec = '0;
      for (int r = 0; r < NUM_REGS; r++)
        for (int p = 0; p < NUM_WB; p++)
          if (wb_valid[p] && wb_tid_bitmap[p*NUM_TID+t] && wb_dest_reg[p*REG_W +: REG_W] == REG_W'(r))
            dec[r] = dec[r] + DEC_W'(1);
    end
    scoreboard_row #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_row (
      .clk(clk),
      .rst(rst),
      .inc((accept && rsv_tid == TID_W'(t)) ? rsv_regs_map : '0),
      .dec(dec),
      .flush(flush_valid && flush_tid == TID_W'(t)),
      .busy(busy[t]),
      .full(full[t]),
      .zero(zero[t]),
      .underflow(uf[t])
    );
  end
  always_ff @(posedge clk) begin
    idle <= rst ? 1'b1 : &zero;
    err_underflow <= rst ? 1'b0 : err_underflow | (|uf);
  end
endmodule

// File: tb/tb_scoreboard_mc.sv
// tb_scoreboard_mc: directed table and corner sequences for scoreboard_mc
module tb_scoreboard_mc;
  import scoreboard_pkg::*;
  localparam int NT = 256, NW = 2, TW = 8, RW = 7;
  logic clk = 0, rst = 1;
  reg_map_t input_regs_map, rsv_regs_map;
  logic [TW-1:0] rd_tid, rsv_tid, flush_tid;
  logic rd_valid, rsv_valid, flush_valid;
  logic [NW*NT-1:0] wb_tid_bitmap;
  logic [NW*RW-1:0] wb_dest_reg;
  logic [NW-1:0] wb_valid;
  logic rsv_ready, collision, idle, err_underflow;
  int n_cmp = 0, n_bad = 0;
  logic bp_exp;

  scoreboard_mc dut (
    .clk(clk), .rst(rst), .input_regs_map(input_regs_map), .rd_tid(rd_tid), .rd_valid(rd_valid),
    .rsv_regs_map(rsv_regs_map), .rsv_tid(rsv_tid), .rsv_valid(rsv_valid), .rsv_ready(rsv_ready),
    .wb_tid_bitmap(wb_tid_bitmap), .wb_dest_reg(wb_dest_reg), .wb_valid(wb_valid),
    .flush_tid(flush_tid), .flush_valid(flush_valid), .collision(collision), .idle(idle),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] rsv_t; reg_map_t rsv_m; logic rsv_v;
    logic [TW-1:0] rd_t; reg_map_t rd_m; logic rd_v;
    logic coll; logic ready; logic idl;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic clr();
    input_regs_map = '0; rd_tid = '0; rd_valid = 0;
    rsv_regs_map = '0; rsv_tid = '0; rsv_valid = 0;
    wb_tid_bitmap = '0; wb_dest_reg = '0; wb_valid = '0;
    flush_tid = '0; flush_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1; clr();
  endtask

  task automatic rsv(input int t, input reg_map_t m);
    rsv_tid = TW'(t); rsv_regs_map = m; rsv_valid = 1;
  endtask

  task automatic wb(input int p, input int t, input int r);
    wb_valid[p] = 1; wb_tid_bitmap[p*NT+t] = 1; wb_dest_reg[p*RW +: RW] = RW'(r);
  endtask

  task automatic coll(input string nm, input int t, input reg_map_t m, input logic exp);
    rd_tid = TW'(t); input_regs_map = m; rd_valid = 1; #1;
    chk(nm, collision, exp);
  endtask

  initial begin
    vt[0]  = '{8'd0, 34'h0, 0, 8'd100, 34'h3_FFFF_FFFF, 1, 0, 1, 1};
    vt[1]  = '{8'd5, 34'hF, 1, 8'd5, 34'h6, 1, 0, 1, 1};
    vt[2]  = '{8'd0, 34'h0, 0, 8'd5, 34'h6, 1, 1, 1, 0};
    vt[3]  = '{8'd0, 34'h0, 0, 8'd5, 34'hF0, 1, 0, 1, 0};
    vt[4]  = '{8'd0, 34'h0, 0, 8'd6, 34'hF, 1, 0, 1, 0};
    vt[5]  = '{8'd0, 34'h0, 0, 8'd5, 34'h6, 0, 0, 1, 0};
    vt[6]  = '{8'd7, 34'h1, 1, 8'd7, 34'h1, 1, 0, 1, 0};
    vt[7]  = '{8'd7, 34'h1, 1, 8'd7, 34'h1, 1, 1, 1, 0};
    vt[8]  = '{8'd7, 34'h1, 1, 8'd7, 34'h1, 1, 1, 1, 0};
    vt[9]  = '{8'd7, 34'h1, 1, 8'd7, 34'h1, 1, 1, 0, 0};
    vt[10] = '{8'd7, 34'h3, 1, 8'd7, 34'h2, 1, 0, 0, 0};
`ifdef SCOREBOARD_WB_BYPASS_EN
    bp_exp = 0;
`else
    bp_exp = 1;
`endif
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 0; #1;
    chk("reset_idle", idle, 1);
    chk("reset_err", err_underflow, 0);
    chk("reset_ready", rsv_ready, 1);
    chk("reset_coll", collision, 0);

    for (int i = 0; i < 11; i++) begin
      rsv_tid = vt[i].rsv_t; rsv_regs_map = vt[i].rsv_m; rsv_valid = vt[i].rsv_v;
      rd_tid = vt[i].rd_t; input_regs_map = vt[i].rd_m; rd_valid = vt[i].rd_v;
      #1;
      chk($sformatf("vec%0d_coll", i), collision, vt[i].coll);
      chk($sformatf("vec%0d_ready", i), rsv_ready, vt[i].ready);
      chk($sformatf("vec%0d_idle", i), idle, vt[i].idl);
      tick();
    end

    wb(0, 5, 0); wb(1, 5, 1); tick();
    wb(0, 5, 2); wb(1, 5, 3); tick();
    coll("tid5_free", 5, 34'hF, 0);
    wb(0, 7, 0); wb(1, 7, 0); tick();
    coll("tid7_one_left", 7, 34'h1, 1);
    chk("tid7_not_idle", idle, 0);
    wb(0, 7, 0); tick();
    coll("tid7_free", 7, 34'h1, 0);
    chk("idle_after_release", idle, 1);
    chk("no_err_after_release", err_underflow, 0);

    rsv(7, 34'h20); tick();
    rsv(7, 34'hF); wb(0, 7, 5); #1;
    chk("fusion_ready", rsv_ready, 1);
    tick();
    coll("fusion_reg5_free", 7, 34'h20, 0);
    coll("fusion_reg0_busy", 7, 34'h1, 1);
    chk("fusion_no_err", err_underflow, 0);
    wb(0, 7, 0); wb(1, 7, 1); tick();
    wb(0, 7, 2); wb(1, 7, 3); tick();
    chk("fusion_idle", idle, 1);

    rsv(3, 34'h1); tick();
    wb(0, 3, 34); tick();
    coll("oob_dest_ignored", 3, 34'h1, 1);
    chk("oob_no_err", err_underflow, 0);
    wb(0, 3, 0); tick();

    rsv(10, 34'h4); tick();
    rsv(11, 34'h4); tick();
    wb(0, 10, 2); wb(1, 11, 2);
    coll("bypass_same_cycle", 10, 34'h4, bp_exp);
    tick();
    coll("bypass_next_cycle", 10, 34'h4, 0);
    coll("tid11_released", 11, 34'h4, 0);
    chk("bypass_no_err", err_underflow, 0);

    rsv(22, reg_map_t'(1) << REG_PR); tick();
    rsv(22, reg_map_t'(1) << REG_CR); flush_tid = 8'd22; flush_valid = 1;
    wb(0, 22, 0); tick();
    coll("flush_clears_row", 22, reg_map_t'(3) << REG_CR, 0);
    chk("flush_idle", idle, 1);
    chk("flush_no_err", err_underflow, 0);

    wb(0, 9, 4); tick();
    chk("underflow_set", err_underflow, 1);
    coll("underflow_clamped", 9, 34'h10, 0);
    tick(); tick();
    chk("underflow_sticky", err_underflow, 1);

    rsv(1, 34'hFF); tick();
    rsv(2, 34'hF); tick();
    chk("burst_busy", idle, 0);
    rst = 1; rsv(3, 34'h1); wb(0, 1, 0); tick();
    rst = 0; #1;
    chk("rst_idle", idle, 1);
    chk("rst_err", err_underflow, 0);
    coll("rst_tid1", 1, 34'hFF, 0);
    coll("rst_tid2", 2, 34'hF, 0);
    coll("rst_tid3", 3, 34'h1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
